mux4to1_rr_stream: RTL and testbench

Four-input, one-output stream merger: collects 4-bit beats from four valid/ready source channels and forwards them, one per cycle, onto a single registered output channel tagged with the originating channel index. Arbitration is round-robin. It is the gather side of the design's 1-to-4 demultiplexer: `out_sel` carries the same 2-bit encoding the demultiplexer's `sel` uses (0..3 → y0..y3). A merged stream can therefore be split back out without translation.

---
 rtl/mux4to1_rr_stream.sv | 99 +++++++++
 tb/tb_mux4to1_rr_stream.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1_rr_stream.sv
// Four-channel valid/ready stream merger with round-robin arbitration.
// Output beats are registered and tagged with the source channel index.
module mux4to1_rr_stream #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  input  logic              out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [1:0]        ptr_q, ptr_d;

  logic              load;
  logic              accept;
  logic              grant_vld;
  logic [1:0]        grant;
  logic [1:0]        idx;
  logic [DATA_W-1:0] grant_data;

  assign load   = !out_valid_q || out_ready;
  assign accept = load && grant_vld;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (grant)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  // Gated by rst_n so no source sees a handshake while the block is held in reset.
  always_comb begin
    in_ready = '0;
    if (accept && rst_n) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
      ptr_d       = grant + 2'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4to1_rr_stream.sv
// Bench for mux4to1_rr_stream: per-cycle reference model plus directed
// literal expectations for reset, round-robin, backpressure and drain.
module tb_mux4to1_rr_stream;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_ptr;
  logic       m_valid;
  logic [3:0] m_data;
  logic [1:0] m_sel;

  mux4to1_rr_stream #(.DATA_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] data_of(input int c);
    case (c)
      0:       return in_data0;
      1:       return in_data1;
      2:       return in_data2;
      default: return in_data3;
    endcase
  endfunction

  // Compare DUT against the model, then advance the model across the coming edge.
  task automatic model_cmp();
    int         g;
    bit         load;
    logic [3:0] exp_rdy;
    if (!rst_n) begin
      check("rst_valid", 8'(out_valid), 8'h0);
      check("rst_data", 8'(out_data), 8'h0);
      check("rst_sel", 8'(out_sel), 8'h0);
      check("rst_ready", 8'(in_ready), 8'h0);
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = '0;
    end else begin
      load = !m_valid || out_ready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      check("mdl_ready", 8'(in_ready), 8'(exp_rdy));
      check("mdl_valid", 8'(out_valid), 8'(m_valid));
      check("mdl_data", 8'(out_data), 8'(m_data));
      check("mdl_sel", 8'(out_sel), 8'(m_sel));
      if (load && g >= 0) begin
        m_valid = 1'b1;
        m_data  = data_of(g);
        m_sel   = 2'(g);
        m_ptr   = (g + 1) % 4;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cmp();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] vt [12];
  logic       rt [12];

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data0  = '0;
    in_data1  = '0;
    in_data2  = '0;
    in_data3  = '0;
    out_ready = 1'b0;
    m_ptr     = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_sel     = '0;

    #1;
    check("init_valid", 8'(out_valid), 8'h0);
    check("init_sel", 8'(out_sel), 8'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single channel
    in_valid  = 4'b0100;
    in_data2  = 4'hA;
    out_ready = 1'b1;
    #1;
    check("single_ready", 8'(in_ready), 8'h04);
    tick();
    check("single_valid", 8'(out_valid), 8'h1);
    check("single_data", 8'(out_data), 8'hA);
    check("single_sel", 8'(out_sel), 8'h2);

    // Asynchronous reset with a beat in flight (sel=2, ptr=3)
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 8'(out_valid), 8'h0);
    check("arst_data", 8'(out_data), 8'h0);
    check("arst_sel", 8'(out_sel), 8'h0);
    check("arst_ready", 8'(in_ready), 8'h0);
    in_valid = 4'b1111;
    in_data0 = 4'h1;
    in_data1 = 4'h2;
    in_data2 = 4'h3;
    in_data3 = 4'h4;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_sel", 8'(out_sel), 8'h0);
    check("post_rst_data", 8'(out_data), 8'h1);

    // Full round-robin, no bubbles
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rr_valid", 8'(out_valid), 8'h1);
      check("rr_sel", 8'(out_sel), 8'(i % 4));
      check("rr_data", 8'(out_data), 8'(i % 4 + 1));
    end

    // Backpressure while sel=1 is held
    out_ready = 1'b0;
    #1;
    check("bp_ready", 8'(in_ready), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_sel", 8'(out_sel), 8'h1);
      check("bp_data", 8'(out_data), 8'h2);
      check("bp_ready_hold", 8'(in_ready), 8'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 8'(in_ready), 8'h04);
    tick();
    check("bp_next_sel", 8'(out_sel), 8'h2);

    // Two continuous requesters alternate (ptr is 3 here)
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fair_sel", 8'(out_sel), (i % 2 == 0) ? 8'h3 : 8'h0);
    end

    // Drain to empty
    in_valid = 4'b0010;
    in_data1 = 4'h5;
    tick();
    check("drain_valid1", 8'(out_valid), 8'h1);
    in_valid = 4'b0000;
    tick();
    check("drain_valid0", 8'(out_valid), 8'h0);
    check("drain_data", 8'(out_data), 8'h5);
    check("drain_sel", 8'(out_sel), 8'h1);
    tick();
    check("idle_valid", 8'(out_valid), 8'h0);
    check("idle_sel", 8'(out_sel), 8'h1);

    // Mixed valid/ready patterns, checked by the model only
    vt = '{4'b0011, 4'b0110, 4'b1000, 4'b1111, 4'b0101, 4'b0000,
           4'b1010, 4'b1110, 4'b0001, 4'b1111, 4'b0100, 4'b1001};
    rt = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
           1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      in_valid  = vt[i];
      out_ready = rt[i];
      in_data0  = 4'(i + 6);
      in_data1  = 4'(i + 7);
      in_data2  = 4'(i + 8);
      in_data3  = 4'(i + 9);
      tick();
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
